// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: preamble, payload MSB first, optional even parity, one gap bit
// All outputs are registered; a start seen in GAP chains the next frame with no idle cycle.
module seq_frame_tx #(
  parameter int                 DATA_W    = 8,
  parameter int                 PRE_W     = 4,
  parameter logic [PRE_W-1:0]   PREAMBLE  = 4'b1100,
  parameter bit                 PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'((DATA_W > 1) ? DATA_W - 2 : 0);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [PRE_W-1:0]  r_pre;
  logic              r_par;
  logic              w_accept;

  assign w_accept = start && ((r_state == IDLE) || (r_state == GAP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_pre   <= '0;
      r_par   <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      dout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        // First preamble bit goes out straight away; the rest is shifted from r_pre.
        r_state <= PRE;
        r_cnt   <= '0;
        r_shreg <= din;
        r_par   <= ^din;
        r_pre   <= PREAMBLE << 1;
        ready   <= 1'b0;
        busy    <= 1'b1;
        dout    <= PREAMBLE[PRE_W-1];
      end else begin
        case (r_state)
          IDLE: begin
            dout <= 1'b0;
          end
          PRE: begin
            if (r_cnt == PRE_LAST) begin
              r_state <= DATA;
              r_cnt   <= '0;
              dout    <= r_shreg[DATA_W-1];
              r_shreg <= r_shreg << 1;
              done    <= !PARITY_EN && (DATA_W == 1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              dout  <= r_pre[PRE_W-1];
              r_pre <= r_pre << 1;
            end
          end
          DATA: begin
            if (r_cnt == DATA_LAST) begin
              r_cnt <= '0;
              if (PARITY_EN) begin
                r_state <= PAR;
                dout    <= r_par;
                done    <= 1'b1;
              end else begin
                r_state <= GAP;
                dout    <= 1'b0;
              end
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              dout    <= r_shreg[DATA_W-1];
              r_shreg <= r_shreg << 1;
              done    <= !PARITY_EN && (DATA_W > 1) && (r_cnt == DATA_PEN);
            end
          end
          PAR: begin
            r_state <= GAP;
            r_cnt   <= '0;
            dout    <= 1'b0;
          end
          GAP: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            dout    <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            dout    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - directed table and sequence bench for seq_frame_tx (parity and no-parity instances)
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_p, start_n;
  logic [7:0] din_p, din_n;
  logic       ready_p, dout_p, busy_p, done_p;
  logic       ready_n, dout_n, busy_n, done_n;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seq_frame_tx u_dut (
    .clk(clk), .rst(rst), .start(start_p), .din(din_p),
    .ready(ready_p), .dout(dout_p), .busy(busy_p), .done(done_p)
  );

  seq_frame_tx #(.PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .start(start_n), .din(din_n),
    .ready(ready_n), .dout(dout_n), .busy(busy_n), .done(done_n)
  );

  typedef struct {
    bit          np;
    logic [7:0]  din;
    logic [13:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic capture(input bit np, input int n, input int poke,
                         output logic [13:0] f, output logic [13:0] dv, output logic [13:0] bv);
    f = '0; dv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      f  = {f[12:0],  np ? dout_n : dout_p};
      dv = {dv[12:0], np ? done_n : done_p};
      bv = {bv[12:0], np ? busy_n : busy_p};
      if (poke >= 0 && i == poke) begin start_p = 1'b1; din_p = 8'h00; end
      if (poke >= 0 && i == poke + 1) start_p = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input bit np, input logic [13:0] exp_f,
                             input logic [13:0] f, input logic [13:0] dv, input logic [13:0] bv);
    chk({name, "_frame"}, 32'(f), 32'(exp_f));
    chk({name, "_done"},  32'(dv), 32'(14'd2));
    chk({name, "_busy"},  32'(bv), np ? 32'h1FFF : 32'h3FFF);
  endtask

  task automatic send(input string name, input bit np, input logic [7:0] d, input logic [13:0] exp_f);
    logic [13:0] f, dv, bv;
    int n = 0;
    while (!(np ? ready_n : ready_p) && n < 64) begin @(negedge clk); n++; end
    chk({name, "_ready_wait"}, 32'(np ? ready_n : ready_p), 32'd1);
    if (np) begin start_n = 1'b1; din_n = d; end
    else    begin start_p = 1'b1; din_p = d; end
    @(posedge clk);
    @(negedge clk);
    start_p = 1'b0; start_n = 1'b0;
    if (np) din_n = ~d; else din_p = ~d;
    capture(np, np ? 13 : 14, -1, f, dv, bv);
    check_frame(name, np, exp_f, f, dv, bv);
    chk({name, "_idle_after"}, np ? 32'({ready_n, busy_n, dout_n}) : 32'({ready_p, busy_p, dout_p}), 32'b100);
  endtask

  initial begin
    logic [13:0] f, dv, bv;
    vecs[0] = '{1'b0, 8'hA5, 14'b11001010010100};
    vecs[1] = '{1'b0, 8'h00, 14'b11000000000000};
    vecs[2] = '{1'b0, 8'h01, 14'b11000000000110};
    vecs[3] = '{1'b1, 8'h07, 14'b01100000001110};
    vecs[4] = '{1'b1, 8'hA5, 14'b01100101001010};

    // Reset held with start high: outputs stay idle, first edge after release accepts.
    rst = 1'b0; start_p = 1'b1; din_p = 8'h07; start_n = 1'b0; din_n = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", 32'({dout_p, ready_p, busy_p, done_p}), 32'b0100);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_p = 1'b0; din_p = 8'hF0;
    capture(1'b0, 14, -1, f, dv, bv);
    check_frame("single_07", 1'b0, 14'b11000000011110, f, dv, bv);
    chk("single_07_idle", 32'({ready_p, busy_p, dout_p}), 32'b100);

    for (int i = 0; i < 5; i++)
      send($sformatf("vec%0d", i), vecs[i].np, vecs[i].din, vecs[i].frame);

    // Start pulsed and din cleared mid-frame must not disturb the frame in flight.
    start_p = 1'b1; din_p = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start_p = 1'b0;
    capture(1'b0, 14, 4, f, dv, bv);
    check_frame("ignore_ff", 1'b0, 14'b11001111111100, f, dv, bv);
    @(negedge clk);
    chk("ignore_no_restart", 32'({ready_p, busy_p, dout_p}), 32'b100);

    // Start tied high: frames chain every 14 cycles with one gap bit.
    start_p = 1'b1; din_p = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    capture(1'b0, 14, -1, f, dv, bv);
    check_frame("cont_1", 1'b0, 14'b11000011110000, f, dv, bv);
    chk("cont_rearm", 32'({ready_p, busy_p, dout_p}), 32'b011);
    capture(1'b0, 14, -1, f, dv, bv);
    check_frame("cont_2", 1'b0, 14'b11000011110000, f, dv, bv);
    start_p = 1'b0;
    send("cont_drain", 1'b0, 8'h81, 14'b11001000000100);

    // Asynchronous reset in the middle of the payload on both instances.
    start_p = 1'b1; din_p = 8'hA5; start_n = 1'b1; din_n = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    start_p = 1'b0; start_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_pre", 32'({dout_p, busy_p, dout_n, busy_n}), 32'b1111);
    #2 rst = 1'b0;
    #1;
    chk("midrst_p", 32'({dout_p, ready_p, busy_p, done_p}), 32'b0100);
    chk("midrst_n", 32'({dout_n, ready_n, busy_n, done_n}), 32'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_resume", 32'({ready_p, busy_p, ready_n, busy_n}), 32'b1010);
    send("after_rst_p", 1'b0, 8'h81, 14'b11001000000100);
    send("after_rst_n", 1'b1, 8'h81, 14'b01100100000010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter for the serial-detector protocol, the sending end of the 1100 sequence detector. It accepts a parallel payload word through a start/ready handshake and drives a one-bit-per-clock serial line. Each frame is the 4-bit preamble 1100, then the payload MSB first, then an optional even-parity bit, then one forced-low gap bit. Receivers synchronise on the preamble; the frame layout is fixed here.

## Interface

- DATA_W, 8, payload width in bits (≥1)
- PRE_W, 4, preamble width in bits
- PREAMBLE, 4'b1100, preamble pattern, sent MSB first
- PARITY_EN, 1, 1 = append even-parity bit after payload, 0 = omit

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  frame request, sampled on rising clk
- din  input  DATA_W  payload, captured when start & ready
- ready  output  1  high when idle and able to accept start
- dout  output  1  serial line, registered
- busy  output  1  high while a frame (including gap) is in progress
- done  output  1  one-cycle pulse while the final frame bit (parity, or last data bit if PARITY_EN=0) is on dout

## Operation

- States:
  - IDLE: dout=0, ready=1, busy=0.
  - PRE: emits PREAMBLE[PRE_W-1-cnt].
  - DATA: emits shreg MSB, then shifts left.
  - PAR: emits the parity bit.
  - GAP: dout=0.
- Transitions:
  - IDLE→PRE on start=1. din is latched into shreg and parity = ^din is latched.
  - PRE→DATA after PRE_W bits.
  - DATA→PAR after DATA_W bits if PARITY_EN=1, else DATA→GAP.
  - PAR→GAP after 1 bit.
  - GAP→IDLE after 1 bit.
- Bit counter: $clog2(max(PRE_W,DATA_W)) bits, cleared on every state entry; no wrap beyond the terminal count.
- Even parity: the parity bit is 1 iff the payload has an odd number of ones, so the payload plus parity always holds an even count of ones.
- start while busy is ignored. din is not re-sampled mid-frame, so din may change freely after the accepting edge.
- State and outputs are registered (Moore). No combinational path from start or din to dout.
- Async reset (rst=0), effective immediately, mid-frame included:
  - state=IDLE, dout=0, ready=1, busy=0, done=0, counter=0, shreg=0.
  - An aborted frame is not resumed.
- Release of rst is synchronous to clk. The first start is accepted at the first rising edge with rst=1.

## Timing

- Accepting edge k (start=1, ready=1): ready=0 and busy=1 from edge k.
- First preamble bit: on dout during cycle k+1 (the cycle after edge k).
- Frame length: F = PRE_W + DATA_W + PARITY_EN + 1 cycles, ending with GAP in cycle k+F.
- With the defaults F = 14.
- done is high in cycle k+F-1.
- ready returns to 1 at edge k+F (IDLE). A start held high is accepted again at that same edge.
- Back-to-back frames with start held high are therefore separated by exactly one gap bit (0), and dout cycle is F.
- Latency from start to the first payload bit is PRE_W+1 cycles.

## Test plan

- **Reset:** hold rst=0 for 3 cycles with start=1 → dout=0, ready=1, busy=0, done=0 throughout. Release rst; the first accepting edge is the next rising edge.
- **Single frame, default parameters:** din=8'h07, one-cycle start → dout sequence from cycle k+1 is 1,1,0,0, 0,0,0,0,0,1,1,1, 1 (parity, 3 ones), 0 (gap). done is high only on the parity bit; ready rises after 14 cycles.
- **Even payload:** din=8'hA5 → 1100 10100101 0 0. An 1100 detector driven by dout asserts at the end of the preamble.
- **Busy/ignore and din change:** din=8'hFF with start; during the frame pulse start=1 and set din=8'h00 at cycle k+5 → the frame still carries 11111111 with parity 0; no second frame starts until ready=1.
- **Continuous start:** start tied high, din=8'h3C → frames repeat every 14 cycles, each followed by exactly one 0 gap bit; done pulses every 14 cycles.
- **Reset mid-frame and PARITY_EN=0:**
  - Assert rst=0 asynchronously (between clock edges) during the DATA state → dout drops to 0 and ready=1 without waiting for clk. After release, a new frame with din=8'h81 transmits in full.
  - Repeat with PARITY_EN=0: 13-cycle frames, done on the last data bit.
